// File: rtl/sad_pkg.sv
// Shared constants, state encoding and scan order for the five-candidate SAD best-select path.
package sad_pkg;

  localparam int NUM_CAND  = 5;
  localparam int ROW_SAD_W = 12;

  localparam logic [2:0] CAND_RQ   = 3'd0;
  localparam logic [2:0] CAND_RH   = 3'd1;
  localparam logic [2:0] CAND_FULL = 3'd2;
  localparam logic [2:0] CAND_LH   = 3'd3;
  localparam logic [2:0] CAND_LQ   = 3'd4;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } sad_state_e;

  // Step i of the scan reads bits [3*i +: 3]; FULL goes first so it keeps every tie.
  localparam logic [14:0] SCAN_ORDER = {CAND_LQ, CAND_LH, CAND_RH, CAND_RQ, CAND_FULL};

  function automatic logic [2:0] scan_cand(input logic [2:0] step);
    return SCAN_ORDER[3*step +: 3];
  endfunction

endpackage

// File: rtl/sad_best_select_if.sv
// Row-SAD input and best-candidate result channels of sad_best_select.
interface sad_best_select_if import sad_pkg::*; #(
  parameter int ACC_W = 15
);
  // Both channels: a beat transfers on a rising edge where valid && ready; a
  // source holds valid and payload stable until that edge, and ready never
  // depends combinationally on valid.
  logic                            sad_valid;
  logic                            sad_ready;
  logic [NUM_CAND*ROW_SAD_W-1:0]   sad;
  logic                            best_valid;
  logic                            best_ready;
  logic [2:0]                      best_idx;
  logic [ACC_W-1:0]                best_sad;

  modport slave (
    input  sad_valid, sad, best_ready,
    output sad_ready, best_valid, best_idx, best_sad
  );

  modport master (
    output sad_valid, sad, best_ready,
    input  sad_ready, best_valid, best_idx, best_sad
  );
endinterface

// File: rtl/sad_acc_lane.sv
// One saturating accumulator lane: load replaces the total, add sums and clamps at all-ones.
module sad_acc_lane import sad_pkg::*; #(
  parameter int ACC_W = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 add,
  input  logic [ROW_SAD_W-1:0] din,
  output logic [ACC_W-1:0]     acc
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + (ACC_W+1)'(din);
    acc_d = acc_q;
    if (load)
      acc_d = ACC_W'(din);
    else if (add)
      acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/sad_best_select.sv
// Accumulates ROWS rows of five candidate SADs, scans the totals and offers the best one.
// Optional build macro SAD_FRAC_PENALTY_EN biases fractional candidates by FRAC_PENALTY when comparing.
module sad_best_select import sad_pkg::*; #(
  parameter int ROWS         = 8,
  parameter int ACC_W        = 15,
  parameter int FRAC_PENALTY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  sad_best_select_if.slave         sif,
  output logic [1:0]               dbg_state
);

  localparam int          CNT_W    = $clog2(ROWS);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
  localparam logic [1:0]  ST_ACCUM = ACCUM;
  localparam logic [1:0]  ST_SCAN  = SCAN;
  localparam logic [1:0]  ST_DONE  = DONE;
  localparam logic [ACC_W:0] PEN_VAL = (ACC_W+1)'(FRAC_PENALTY);
`ifdef SAD_FRAC_PENALTY_EN
  localparam bit PEN_EN = 1'b1;
`else
  localparam bit PEN_EN = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [2:0]       scan_cnt_q, scan_cnt_d;
  logic [2:0]       best_idx_q, best_idx_d;
  logic [ACC_W-1:0] best_sad_q, best_sad_d;
  logic [ACC_W:0]   best_cmp_q, best_cmp_d;
  logic             sad_ready_q, sad_ready_d;
  logic             best_valid_q, best_valid_d;

  logic [ACC_W-1:0] acc [NUM_CAND];
  logic             accept, lane_load, lane_add;
  logic [2:0]       cand;
  logic [ACC_W-1:0] cand_acc;
  logic [ACC_W:0]   cand_cmp;

  assign accept    = sif.sad_valid && (state_q == ST_ACCUM);
  assign lane_load = accept && (row_cnt_q == '0);
  assign lane_add  = accept && (row_cnt_q != '0);

  for (genvar k = 0; k < NUM_CAND; k++) begin : g_lane
    sad_acc_lane #(.ACC_W(ACC_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (lane_load),
      .add  (lane_add),
      .din  (sif.sad[k*ROW_SAD_W +: ROW_SAD_W]),
      .acc  (acc[k])
    );
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    scan_cnt_d = scan_cnt_q;
    best_idx_d = best_idx_q;
    best_sad_d = best_sad_q;
    best_cmp_d = best_cmp_q;
    cand       = scan_cand(scan_cnt_q);
    cand_acc   = acc[cand];
    // The bias only steers the comparison; best_sad always carries the raw total.
    cand_cmp   = {1'b0, cand_acc} + ((PEN_EN && cand != CAND_FULL) ? PEN_VAL : '0);

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            state_d   = ST_SCAN;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (scan_cnt_q == 3'd0 || cand_cmp < best_cmp_q) begin
          best_idx_d = cand;
          best_sad_d = cand_acc;
          best_cmp_d = cand_cmp;
        end
        if (scan_cnt_q == 3'(NUM_CAND - 1)) begin
          scan_cnt_d = 3'd0;
          state_d    = ST_DONE;
        end else begin
          scan_cnt_d = scan_cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (sif.best_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase

    sad_ready_d  = (state_d == ST_ACCUM);
    best_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      row_cnt_q    <= '0;
      scan_cnt_q   <= 3'd0;
      best_idx_q   <= CAND_FULL;
      best_sad_q   <= '0;
      best_cmp_q   <= '0;
      sad_ready_q  <= 1'b1;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      best_idx_q   <= best_idx_d;
      best_sad_q   <= best_sad_d;
      best_cmp_q   <= best_cmp_d;
      sad_ready_q  <= sad_ready_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign sif.sad_ready  = sad_ready_q;
  assign sif.best_valid = best_valid_q;
  assign sif.best_idx   = best_idx_q;
  assign sif.best_sad   = best_sad_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sad_best_select.sv
// Bench for sad_best_select: a 15-bit and a 14-bit accumulator instance driven in lockstep,
// checked against a whole-block arithmetic reference model.
module tb_sad_best_select;
  import sad_pkg::*;

  localparam int ROWS = 8;
  localparam int PEN  = 4;
`ifdef SAD_FRAC_PENALTY_EN
  localparam bit PEN_EN = 1'b1;
`else
  localparam bit PEN_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] dbg_a, dbg_b;
  int         total = 0;
  int         bad   = 0;

  sad_best_select_if #(.ACC_W(15)) if_a ();
  sad_best_select_if #(.ACC_W(14)) if_b ();

  sad_best_select #(.ROWS(ROWS), .ACC_W(15), .FRAC_PENALTY(PEN)) u_dut_a (
    .clk (clk), .rst (rst), .sif (if_a.slave), .dbg_state (dbg_a)
  );
  sad_best_select #(.ROWS(ROWS), .ACC_W(14), .FRAC_PENALTY(PEN)) u_dut_b (
    .clk (clk), .rst (rst), .sif (if_b.slave), .dbg_state (dbg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: expected (idx, sad) pairs for each instance
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [59:0] pack5(input int lq, input int lh, input int full,
                                        input int rh, input int rq);
    return {12'(lq), 12'(lh), 12'(full), 12'(rh), 12'(rq)};
  endfunction

  // Reference: total each column, clamp, bias fractional ones, pick minimum with FULL-first ties.
  task automatic model(input logic [59:0] rows[$], input int acc_w,
                       output int idx, output int sad);
    longint acc [5];
    longint cmp [5];
    longint mx;
    longint m;
    mx = (longint'(1) << acc_w) - 1;
    for (int k = 0; k < 5; k++) begin
      acc[k] = 0;
      foreach (rows[r]) acc[k] += rows[r][12*k +: 12];
      if (acc[k] > mx) acc[k] = mx;
      cmp[k] = acc[k] + ((PEN_EN && k != 2) ? PEN : 0);
    end
    m = cmp[0];
    for (int k = 1; k < 5; k++) if (cmp[k] < m) m = cmp[k];
    idx = -1;
    if (cmp[2] == m) idx = 2;
    else for (int k = 4; k >= 0; k--) if (cmp[k] == m) idx = k;
    sad = int'(acc[idx]);
  endtask

  task automatic drive(input logic v, input logic [59:0] d);
    if_a.sad_valid = v; if_a.sad = d;
    if_b.sad_valid = v; if_b.sad = d;
  endtask

  task automatic set_best_ready(input logic r);
    if_a.best_ready = r;
    if_b.best_ready = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready_a"}, 32'(if_a.sad_ready), 32'd1);
    chk({tag, "_valid_a"}, 32'(if_a.best_valid), 32'd0);
    chk({tag, "_idx_a"},   32'(if_a.best_idx), 32'd2);
    chk({tag, "_sad_a"},   32'(if_a.best_sad), 32'd0);
    chk({tag, "_state_a"}, 32'(dbg_a), 32'(ACCUM));
    chk({tag, "_idx_b"},   32'(if_b.best_idx), 32'd2);
    chk({tag, "_sad_b"},   32'(if_b.best_sad), 32'd0);
  endtask

  // driver: feed one block, measure latency, check result, optionally stall then hand off
  task automatic run_block(input string tag, input logic [59:0] rows[$], input int stall);
    int ia, sa, ib, sb, lat;
    model(rows, 15, ia, sa);
    model(rows, 14, ib, sb);
    exp_q.push_back(32'(ia)); exp_q.push_back(32'(sa));
    exp_q.push_back(32'(ib)); exp_q.push_back(32'(sb));
    foreach (rows[i]) begin
      @(negedge clk);
      if (i == 0) chk({tag, "_ready_start"}, 32'(if_a.sad_ready & if_b.sad_ready), 32'd1);
      drive(1'b1, rows[i]);
    end
    @(negedge clk);
    drive(1'b0, 60'(pack5($urandom, $urandom, $urandom, $urandom, $urandom)));
    lat = 1;
    while (if_a.best_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd6);
    chk({tag, "_idx_a"}, 32'(if_a.best_idx), exp_q.pop_front());
    chk({tag, "_sad_a"}, 32'(if_a.best_sad), exp_q.pop_front());
    chk({tag, "_idx_b"}, 32'(if_b.best_idx), exp_q.pop_front());
    chk({tag, "_sad_b"}, 32'(if_b.best_sad), exp_q.pop_front());
    chk({tag, "_valid_b"}, 32'(if_b.best_valid), 32'd1);
    chk({tag, "_ready_done"}, 32'(if_a.sad_ready), 32'd0);
    for (int c = 0; c < stall; c++) begin
      drive(1'b1, 60'(pack5($urandom, $urandom, $urandom, $urandom, $urandom)));
      @(negedge clk);
      chk({tag, "_stall_ready"}, 32'(if_a.sad_ready | if_b.sad_ready), 32'd0);
      chk({tag, "_stall_valid"}, 32'(if_a.best_valid & if_b.best_valid), 32'd1);
      chk({tag, "_stall_idx"},   32'(if_a.best_idx), 32'(ia));
      chk({tag, "_stall_sad"},   32'(if_a.best_sad), 32'(sa));
    end
    drive(1'b0, '0);
    set_best_ready(1'b1);
    @(negedge clk);
    set_best_ready(1'b0);
    chk({tag, "_handoff_valid"}, 32'(if_a.best_valid | if_b.best_valid), 32'd0);
    chk({tag, "_handoff_ready"}, 32'(if_a.sad_ready & if_b.sad_ready), 32'd1);
  endtask

  function automatic void fill(ref logic [59:0] q[$], input logic [59:0] row);
    q.delete();
    for (int i = 0; i < ROWS; i++) q.push_back(row);
  endfunction

  initial begin
    logic [59:0] rows[$];
    rst = 1'b1;
    drive(1'b0, '0);
    set_best_ready(1'b0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    fill(rows, pack5(100, 100, 50, 100, 100));
    run_block("full_best", rows, 0);
    fill(rows, pack5(20, 20, 20, 20, 10));
    run_block("rq_best", rows, 0);
    fill(rows, pack5(7, 7, 7, 7, 7));
    run_block("all_tie", rows, 0);
    fill(rows, pack5(5, 9, 9, 5, 9));
    run_block("frac_tie", rows, 0);
    fill(rows, pack5(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF));
    run_block("saturate", rows, 0);

    for (int b = 0; b < 6; b++) begin
      rows.delete();
      for (int i = 0; i < ROWS; i++) begin
        if (b % 2 == 0)
          rows.push_back(pack5($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                               $urandom_range(0, 3), $urandom_range(0, 3)));
        else
          rows.push_back(pack5($urandom_range(1024, 4095), $urandom_range(1024, 4095),
                               $urandom_range(1024, 4095), $urandom_range(1024, 4095),
                               $urandom_range(1024, 4095)));
      end
      run_block($sformatf("rand%0d", b), rows, 0);
    end

    fill(rows, pack5(30, 40, 25, 50, 60));
    run_block("stall", rows, 10);
    fill(rows, pack5(5, 9, 9, 5, 9));
    run_block("after_stall", rows, 0);

    // Abort a block after three rows with an asynchronous reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, pack5(1, 2, 3, 4, 5));
    end
    @(negedge clk);
    drive(1'b1, pack5(1, 2, 3, 4, 5));
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    drive(1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    fill(rows, pack5(300, 200, 400, 100, 250));
    run_block("after_rst", rows, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
